// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int STAT_NE      = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_FERR    = 3;
    localparam int STAT_PERR    = 4;
    localparam int STAT_CNT_LSB = 8;

    localparam logic [31:0] DEF_DATA_ADDR = 32'h0000_0404;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0408;

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO for received bytes.
// The caller never pushes into a full FIFO without a pop, and never pops an empty one.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 8N1 deserialiser, receive FIFO, status/data registers.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity-error flag.
module uart_rx_mmio
    import uart_rx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] DATA_ADDR    = DEF_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    input  logic [31:0] access_addr,
    input  logic        rd_en,
    output logic [31:0] out_data,
    output logic        int_req
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

    logic          rx_s1_q, rx_s2_q, rx_sync;
    rx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d;
    logic          ferr_set, ovr_set, perr_bit;
    logic          int_req_q;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          data_hit, stat_hit, stat_clr;
    logic [31:0]   status;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d, perr_set;
`endif

    assign rx_sync = rx_s2_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_d = ST_START;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_HALF) begin
                    baud_d = '0;
                    if (!rx_sync) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d            = '0;
                    shift_d[bit_idx_q] = rx_sync;
                    if (bit_idx_q == 3'd7) state_d = AFTER_DATA;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d   = '0;
                    perr_set = (rx_sync != ^shift_q);
                    state_d  = ST_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (rx_sync) begin
                        push_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            // A held-low line parks here so it is reported only once.
            ST_BREAK: begin
                if (rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_hit  = (access_addr == DATA_ADDR);
    assign stat_hit  = (access_addr == STAT_ADDR);
    assign fifo_pop  = rd_en && data_hit && !fifo_empty;
    assign stat_clr  = rd_en && stat_hit;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_push = push_q && (!fifo_full || fifo_pop);
    assign ovr_set   = push_q && fifo_full && !fifo_pop;

    assign ovr_d  = (ovr_q  && !stat_clr) || ovr_set;
    assign ferr_d = (ferr_q && !stat_clr) || ferr_set;
`ifdef UART_RX_PARITY_EN
    assign perr_d   = (perr_q && !stat_clr) || perr_set;
    assign perr_bit = perr_q;
`else
    assign perr_bit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            int_req_q <= !fifo_empty;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) perr_q <= 1'b0;
        else          perr_q <= perr_d;
    end
`endif

    // shift_q is stable until the next DATA state, so it can feed the delayed push.
    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (shift_q),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    always_comb begin
        status                                 = '0;
        status[STAT_NE]                        = !fifo_empty;
        status[STAT_FULL]                      = fifo_full;
        status[STAT_OVR]                       = ovr_q;
        status[STAT_FERR]                      = ferr_q;
        status[STAT_PERR]                      = perr_bit;
        status[STAT_CNT_LSB +: 8]              = 8'(fifo_count);
    end

    always_comb begin
        out_data = '0;
        if (data_hit)      out_data = fifo_empty ? 32'h0 : {24'h0, fifo_head};
        else if (stat_hit) out_data = status;
    end

    assign int_req = int_req_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: serial frames in, scoreboard of expected bytes out.
// Build with UART_RX_PARITY_EN defined to exercise 8E1 framing.
module tb_uart_rx_mmio;

    localparam int          CLKS = 16;
    localparam logic [31:0] DADR = 32'h0000_0404;
    localparam logic [31:0] SADR = 32'h0000_0408;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] access_addr = '0;
    logic        rd_en = 1'b0;
    logic [31:0] out_data;
    logic        int_req;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  sb[$];
    logic [31:0] d;

    uart_rx_mmio #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (4),
        .DATA_ADDR    (DADR),
        .STAT_ADDR    (SADR)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx          (rx),
        .access_addr (access_addr),
        .rd_en       (rd_en),
        .out_data    (out_data),
        .int_req     (int_req)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        @(negedge clock);
        access_addr = a;
        #1 v = out_data;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clock);
        access_addr = a;
        rd_en = 1'b1;
        #1 v = out_data;
        @(negedge clock);
        rd_en = 1'b0;
        access_addr = '0;
    endtask

    task automatic read_data_chk(input string tag);
        logic [31:0] v;
        logic [31:0] exp;
        exp = '0;
        if (sb.size() != 0) exp = {24'h0, sb.pop_front()};
        cpu_read(DADR, v);
        chk(tag, v, exp);
    endtask

    task automatic send_bits(input logic [7:0] b);
        @(negedge clock);
        rx = 1'b0;
        repeat (CLKS) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clock);
        end
    endtask

    task automatic send_end(input logic v, input int hold);
        rx = v;
        repeat (hold) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv, input int hold);
        send_bits(b);
`ifdef UART_RX_PARITY_EN
        rx = ^b;
        repeat (CLKS) @(negedge clock);
`endif
        send_end(stopv, hold);
    endtask

    // Catches the push edge and checks int_req lags it by exactly one clock.
    task automatic wait_push(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            access_addr = SADR;
            #1;
            if (out_data[0]) begin
                seen = 1'b1;
                chk({tag, "_irq_pre"}, {31'h0, int_req}, 32'h0);
            end
        end
        chk({tag, "_push_seen"}, {31'h0, seen}, 32'h1);
        if (seen) begin
            @(negedge clock);
            #1 chk({tag, "_irq_rise"}, {31'h0, int_req}, 32'h1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Idle line after reset
        repeat (100) @(negedge clock);
        #1 chk("rst_irq", {31'h0, int_req}, 32'h0);
        peek(SADR, d);        chk("rst_stat", d, 32'h0);
        cpu_read(DADR, d);    chk("empty_data", d, 32'h0);
        peek(SADR, d);        chk("empty_stat", d, 32'h0);

        // Single good byte
        send_frame(8'hA5, 1'b1, 0);
        sb.push_back(8'hA5);
        wait_push("a5");
        peek(SADR, d);        chk("a5_stat", d, 32'h0000_0101);
        read_data_chk("a5_data");
        #1 chk("a5_irq_hold", {31'h0, int_req}, 32'h1);
        @(negedge clock);
        #1 chk("a5_irq_fall", {31'h0, int_req}, 32'h0);
        peek(SADR, d);        chk("a5_stat_after", d, 32'h0);

        // Short glitch is a false start
        @(negedge clock);
        rx = 1'b0;
        repeat (5) @(negedge clock);
        rx = 1'b1;
        repeat (40) @(negedge clock);
        peek(SADR, d);        chk("glitch_stat", d, 32'h0);
        #1 chk("glitch_irq", {31'h0, int_req}, 32'h0);

        // Bad stop bit followed by a long break
        send_frame(8'h3C, 1'b0, CLKS);
        repeat (60) @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        peek(SADR, d);        chk("ferr_stat", d, 32'h0000_0008);
        cpu_read(SADR, d);    chk("ferr_read", d, 32'h0000_0008);
        peek(SADR, d);        chk("ferr_clr", d, 32'h0);

        // Overrun: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, CLKS);
            if (i <= 4) sb.push_back(8'(i));
        end
        repeat (5) @(negedge clock);
        peek(SADR, d);        chk("ovr_stat", d, 32'h0000_0407);
        #1 chk("ovr_irq", {31'h0, int_req}, 32'h1);
        for (int i = 0; i < 4; i++) read_data_chk($sformatf("ovr_data%0d", i));
        peek(SADR, d);        chk("ovr_stat_drain", d, 32'h0000_0004);
        cpu_read(SADR, d);    chk("ovr_read", d, 32'h0000_0004);
        peek(SADR, d);        chk("ovr_clr", d, 32'h0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so the correct even-parity bit is 1
        send_bits(8'h07);
        send_end(1'b0, CLKS);
        send_end(1'b1, CLKS);
        sb.push_back(8'h07);
        repeat (5) @(negedge clock);
        peek(SADR, d);        chk("perr_stat", d, 32'h0000_0111);
        read_data_chk("perr_data");
        cpu_read(SADR, d);    chk("perr_read", d, 32'h0000_0010);
        send_bits(8'h07);
        send_end(1'b1, CLKS);
        send_end(1'b1, CLKS);
        sb.push_back(8'h07);
        repeat (5) @(negedge clock);
        peek(SADR, d);        chk("par_ok_stat", d, 32'h0000_0101);
        read_data_chk("par_ok_data");
`endif

        // Reset in the middle of a frame with a byte pending
        send_frame(8'h11, 1'b1, CLKS);
        @(negedge clock);
        rx = 1'b0;
        repeat (3 * CLKS) @(negedge clock);
        #3 reset_n = 1'b0;
        #1 chk("midrst_irq", {31'h0, int_req}, 32'h0);
        access_addr = SADR;
        #1 chk("midrst_stat", out_data, 32'h0);
        sb.delete();
        rx = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        peek(SADR, d);        chk("postrst_stat", d, 32'h0);
        send_frame(8'h5A, 1'b1, CLKS);
        sb.push_back(8'h5A);
        repeat (5) @(negedge clock);
        peek(SADR, d);        chk("postrst_cnt", d, 32'h0000_0101);
        read_data_chk("postrst_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
